clock_ui_controller: RTL
========================

Name: clock_ui_controller

Overview:
Parametrised user-interface controller for the digital clock.
- Turns raw board buttons into debounced, edge-qualified commands.
- Owns the mode/field-select state machine, key auto-repeat for increment, and the alarm/timer ringer with acknowledge and beep cadence.
- Sits between the board pins and the clock core. Its outputs are mode, select, increment, alarm_enable and timer_enable, and it drives the audio pin.

Parameters:
CLK_FREQ, 100_000_000, clock frequency in Hz; MS_CYC = CLK_FREQ/1000
NUM_MODES, 3, number of modes; mode 0 = clock
TIMER_MODE, 1, mode index of timer
ALARM_MODE, 2, mode index of alarm
NUM_FIELDS, 3, selectable fields; select 0 = none, 1..NUM_FIELDS = sec/min/hour...
DEBOUNCE_MS, 10, stable time before a level change is accepted
REPEAT_DELAY_MS, 500, hold time before auto-repeat starts
REPEAT_RATE_MS, 100, auto-repeat period
TONE_HZ, 1500, ringer tone frequency
BEEP_MS, 250, beep on-time; off-time is equal

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
btn_mode  in  1  raw button: next mode
btn_select  in  1  raw button: next field
btn_inc  in  1  raw button: increment
btn_start  in  1  raw button: timer start/stop
btn_alarm  in  1  raw button: alarm enable toggle
alarm_out  in  1  alarm match level from clock core
timer_out  in  1  timer expiry level from clock core
mode  out  $clog2(NUM_MODES)  current mode
select  out  $clog2(NUM_FIELDS+1)  current field, 0 = none
increment  out  1  one-cycle increment pulse
timer_enable  out  1  timer running
alarm_enable  out  1  alarm armed
ringing  out  1  ringer active
aud_pwm  out  1  audio square wave

Behaviour:
Reset:
- Async assert on reset_n=0; sync deassert not required.
- All outputs 0: mode=0, select=0, increment=0, timer_enable=0, alarm_enable=0, ringing=0, aud_pwm=0.
- Internal counters 0. Debounced levels 0.

Input conditioning (per button):
- 2-FF synchroniser feeds a debouncer.
- Debounced level flips after DEB_CYC = DEBOUNCE_MS*MS_CYC consecutive cycles in which the synchronised value differs from the debounced level. Any agreeing cycle clears the count.
- Press pulse = debounced rising edge, one cycle wide.
- Latency from a clean raw edge to the press pulse: 2 + DEB_CYC cycles (±1).

Ringer FSM, states IDLE and RING:
- IDLE->RING on rising edge of alarm_out or timer_out.
- Entering RING: mode <= ALARM_MODE if alarm_out, else TIMER_MODE; select <= 0. Alarm wins on simultaneous rising edges.
- RING->IDLE when any press pulse occurs (acknowledge) or when alarm_out and timer_out are both 0.
- An acknowledge press is consumed and performs no other action. A timer-source acknowledge also clears timer_enable.
- ringing = 1 in RING.

Ringer output:
- In RING, aud_pwm toggles every HALF = CLK_FREQ/(2*TONE_HZ) cycles during the beep-on window and is held 0 during the beep-off window.
- Windows alternate at BEEP_MS*MS_CYC cycles each, starting with on at RING entry.
- aud_pwm = 0 in IDLE, and is 0 the cycle after leaving RING.

Command handling (IDLE only, in priority order; at most one command per cycle; lower-priority press pulses in the same cycle are dropped):
1. mode press:
   - mode <= mode+1, wrapping NUM_MODES-1 -> 0.
   - select <= 1 if the new mode != 0, else 0.
   - Auto-repeat is cancelled.
2. select press: select <= select+1, wrapping NUM_FIELDS -> 0.
3. start press: toggle timer_enable only when mode == TIMER_MODE; otherwise ignored.
4. alarm press: toggle alarm_enable in any mode.
5. inc press: increment pulse for one cycle, only when select != 0.

Auto-repeat:
- While btn_inc's debounced level stays 1 and select != 0: first repeat pulse REPEAT_DELAY_MS*MS_CYC cycles after the press pulse, then one every REPEAT_RATE_MS*MS_CYC cycles.
- Release, select becoming 0, or entering RING stops repeat immediately.

Optional Feature:
KEY_REPEAT_EN
- Defined: auto-repeat on btn_inc as specified.
- Undefined: repeat counters are absent, and increment pulses exactly once per debounced press.

Test Plan:
Bench parameters for all scenarios: CLK_FREQ=10000 (MS_CYC=10), DEBOUNCE_MS=1, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2, TONE_HZ=1000, BEEP_MS=2.
1. btn_alarm high for 15 cycles -> alarm_enable 0->1 about 12 cycles after the edge. A 5-cycle glitch -> no change.
2. Three mode presses from reset -> mode 1 (select 1), 2 (select 1), 0 (select 0). Four select presses from mode 1 -> select 2,3,0,1.
3. With select=1, hold btn_inc 100 cycles -> increment pulses at about +12, +62, +82, +102 cycles after the edge. With KEY_REPEAT_EN undefined -> only the +12 pulse.
4. Mode 0 with a start press -> timer_enable stays 0. Mode 1 with a start press -> timer_enable 1.
5. Rising edge on timer_out -> ringing=1, mode=1, select=0. aud_pwm toggles every 5 cycles for 20 cycles, then stays 0 for 20 cycles. A btn_mode press then gives ringing=0, timer_enable=0, mode unchanged.
6. alarm_out and timer_out rising in the same cycle -> mode=2. Pulse reset_n low mid-ring -> all outputs 0 immediately.

Source files
------------

// File: rtl/clock_ui_controller_if.sv
// -----------------------------------------------------------------------------
// clock_ui_controller_if
// Bundles the board-side buttons, the clock-core status levels and the
// user-interface outputs of clock_ui_controller into one interface.
//
// Ports (signals):
//   btn_mode, btn_select, btn_inc, btn_start, btn_alarm : raw buttons
//   alarm_out, timer_out : status levels from the clock core
//   mode, select         : current mode / field (0 = none)
//   increment            : one-cycle increment pulse
//   timer_enable         : timer running
//   alarm_enable         : alarm armed
//   ringing, aud_pwm     : ringer state and audio square wave
//
// Modports:
//   master : board / clock-core side (drives buttons and status levels)
//   slave  : the controller (drives the UI outputs)
// -----------------------------------------------------------------------------
interface clock_ui_controller_if #(
   parameter int NUM_MODES  = 3,
   parameter int NUM_FIELDS = 3
);
   localparam int MODE_W = $clog2(NUM_MODES);
   localparam int SEL_W  = $clog2(NUM_FIELDS + 1);

   logic              btn_mode;
   logic              btn_select;
   logic              btn_inc;
   logic              btn_start;
   logic              btn_alarm;
   logic              alarm_out;
   logic              timer_out;
   logic [MODE_W-1:0] mode;
   logic [SEL_W-1:0]  select;
   logic              increment;
   logic              timer_enable;
   logic              alarm_enable;
   logic              ringing;
   logic              aud_pwm;

   modport master (
      output btn_mode, btn_select, btn_inc, btn_start, btn_alarm,
      output alarm_out, timer_out,
      input  mode, select, increment, timer_enable, alarm_enable,
      input  ringing, aud_pwm
   );

   modport slave (
      input  btn_mode, btn_select, btn_inc, btn_start, btn_alarm,
      input  alarm_out, timer_out,
      output mode, select, increment, timer_enable, alarm_enable,
      output ringing, aud_pwm
   );
endinterface

// File: rtl/clock_ui_controller.sv
// -----------------------------------------------------------------------------
// clock_ui_controller
// User-interface controller for the digital clock. Debounces the board
// buttons into one-cycle press pulses, steps the mode / field selection,
// generates increment pulses (with optional key auto-repeat), toggles the
// timer / alarm enables and runs the alarm/timer ringer with a beeping
// square-wave tone.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   ui       : clock_ui_controller_if.slave (buttons, alarm_out, timer_out,
//              mode, select, increment, timer_enable, alarm_enable,
//              ringing, aud_pwm)
//
// Configuration macro:
//   KEY_REPEAT_EN : when defined, holding btn_inc auto-repeats the increment
//                   pulse; when undefined, one increment per press.
// -----------------------------------------------------------------------------
module clock_ui_controller #(
   parameter int CLK_FREQ        = 100_000_000,
   parameter int NUM_MODES       = 3,
   parameter int TIMER_MODE      = 1,
   parameter int ALARM_MODE      = 2,
   parameter int NUM_FIELDS      = 3,
   parameter int DEBOUNCE_MS     = 10,
   parameter int REPEAT_DELAY_MS = 500,
   parameter int REPEAT_RATE_MS  = 100,
   parameter int TONE_HZ         = 1500,
   parameter int BEEP_MS         = 250
) (
   input logic                  clk,
   input logic                  reset_n,
   clock_ui_controller_if.slave ui
);
   localparam int MS_CYC   = CLK_FREQ / 1000;
   localparam int DEB_CYC  = DEBOUNCE_MS * MS_CYC;
   localparam int HALF     = CLK_FREQ / (2 * TONE_HZ);
   localparam int BEEP_CYC = BEEP_MS * MS_CYC;
   localparam int MODE_W   = $clog2(NUM_MODES);
   localparam int SEL_W    = $clog2(NUM_FIELDS + 1);
   localparam int DEB_W    = $clog2(DEB_CYC + 1);
   localparam int HALF_W   = $clog2(HALF + 1);
   localparam int BEEP_W   = $clog2(BEEP_CYC + 1);

   localparam int B_MODE  = 0;
   localparam int B_SEL   = 1;
   localparam int B_START = 2;
   localparam int B_ALARM = 3;
   localparam int B_INC   = 4;

   typedef enum logic {IDLE, RING} ring_state_t;

   ring_state_t       state_q, state_d;
   logic [4:0]        btn_raw, sync1, sync2, deb, deb_d, press;
   logic [DEB_W-1:0]  deb_cnt [5];
   logic              alarm_d, timer_d, alarm_rise, timer_rise;
   logic              ring_start, ack, cmd_ok;
   logic              mode_cmd, sel_cmd, start_cmd, alarm_cmd, inc_cmd;
   logic              rep_fire;
   logic              ring_timer;
   logic [MODE_W-1:0] mode_q, mode_next;
   logic [SEL_W-1:0]  sel_q;
   logic              increment_q, timer_en_q, alarm_en_q;
   logic [HALF_W-1:0] half_cnt;
   logic [BEEP_W-1:0] beep_cnt;
   logic              tone_q, beep_on;

   assign btn_raw = {ui.btn_inc, ui.btn_alarm, ui.btn_start, ui.btn_select, ui.btn_mode};

   // Two-flop synchroniser followed by a counting debouncer; any cycle that
   // agrees with the current debounced level restarts the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         deb_d <= deb;
         for (int i = 0; i < 5; i++) begin
            if (sync2[i] != deb[i]) begin
               if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
                  deb[i]     <= sync2[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   assign press = deb & ~deb_d;

   // Edge detection on the clock-core status levels
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alarm_d <= 1'b0;
         timer_d <= 1'b0;
      end else begin
         alarm_d <= ui.alarm_out;
         timer_d <= ui.timer_out;
      end
   end

   assign alarm_rise = ui.alarm_out & ~alarm_d;
   assign timer_rise = ui.timer_out & ~timer_d;
   assign ring_start = (state_q == IDLE) && (alarm_rise || timer_rise);
   assign ack        = (state_q == RING) && (|press);

   // Ringer state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Ringer next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (alarm_rise || timer_rise) state_d = RING;
         RING: if (ack || (!ui.alarm_out && !ui.timer_out)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Ringer outputs; the tone is gated by the state so it drops the cycle
   // the ringer returns to IDLE.
   always_comb begin
      ui.ringing = (state_q == RING);
      ui.aud_pwm = (state_q == RING) && beep_on && tone_q;
   end

   // Tone and beep-window counters run only while ringing, so every ring
   // starts with the on-window and a low tone phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         half_cnt <= '0;
         beep_cnt <= '0;
         tone_q   <= 1'b0;
         beep_on  <= 1'b1;
      end else if (state_q != RING) begin
         half_cnt <= '0;
         beep_cnt <= '0;
         tone_q   <= 1'b0;
         beep_on  <= 1'b1;
      end else if (beep_cnt == BEEP_W'(BEEP_CYC - 1)) begin
         beep_cnt <= '0;
         beep_on  <= ~beep_on;
         half_cnt <= '0;
         tone_q   <= 1'b0;
      end else begin
         beep_cnt <= beep_cnt + BEEP_W'(1);
         if (half_cnt == HALF_W'(HALF - 1)) begin
            half_cnt <= '0;
            tone_q   <= ~tone_q;
         end else begin
            half_cnt <= half_cnt + HALF_W'(1);
         end
      end
   end

   // Command decode: one command per cycle, by priority, only when idle and
   // not about to start ringing.
   always_comb begin
      cmd_ok    = (state_q == IDLE) && !ring_start;
      mode_cmd  = cmd_ok && press[B_MODE];
      sel_cmd   = cmd_ok && !press[B_MODE] && press[B_SEL];
      start_cmd = cmd_ok && (press[B_SEL:B_MODE] == 2'b00) && press[B_START];
      alarm_cmd = cmd_ok && (press[B_START:B_MODE] == 3'b000) && press[B_ALARM];
      inc_cmd   = cmd_ok && (press[B_ALARM:B_MODE] == 4'b0000) && press[B_INC]
                  && (sel_q != '0);
      mode_next = (mode_q == MODE_W'(NUM_MODES - 1)) ? '0 : mode_q + MODE_W'(1);
   end

`ifdef KEY_REPEAT_EN
   localparam int REP_DLY = REPEAT_DELAY_MS * MS_CYC;
   localparam int REP_RAT = REPEAT_RATE_MS * MS_CYC;
   localparam int REP_MAX = (REP_DLY > REP_RAT) ? REP_DLY : REP_RAT;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   logic             rep_armed, rep_first;
   logic [REP_W-1:0] rep_cnt;

   assign rep_fire = rep_armed &&
                     (rep_first ? (rep_cnt == REP_W'(REP_DLY - 1))
                                : (rep_cnt == REP_W'(REP_RAT - 1)));

   // Auto-repeat is armed by an accepted increment press and dropped as soon
   // as the key is released, the field is cleared, a mode change happens or
   // the ringer takes over.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rep_armed <= 1'b0;
         rep_first <= 1'b0;
         rep_cnt   <= '0;
      end else if (inc_cmd) begin
         rep_armed <= 1'b1;
         rep_first <= 1'b1;
         rep_cnt   <= '0;
      end else if (!deb[B_INC] || (sel_q == '0) || (state_q != IDLE) ||
                   ring_start || mode_cmd) begin
         rep_armed <= 1'b0;
         rep_first <= 1'b0;
         rep_cnt   <= '0;
      end else if (rep_fire) begin
         rep_first <= 1'b0;
         rep_cnt   <= '0;
      end else if (rep_armed) begin
         rep_cnt <= rep_cnt + REP_W'(1);
      end
   end
`else
   assign rep_fire = 1'b0;
`endif

   // Mode / select / enable registers and the increment pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q      <= '0;
         sel_q       <= '0;
         increment_q <= 1'b0;
         timer_en_q  <= 1'b0;
         alarm_en_q  <= 1'b0;
         ring_timer  <= 1'b0;
      end else begin
         increment_q <= inc_cmd || (rep_fire && cmd_ok && (sel_q != '0));
         if (ring_start) begin
            mode_q     <= ui.alarm_out ? MODE_W'(ALARM_MODE) : MODE_W'(TIMER_MODE);
            sel_q      <= '0;
            ring_timer <= !ui.alarm_out;
         end else if (ack) begin
            if (ring_timer) timer_en_q <= 1'b0;
         end else if (mode_cmd) begin
            mode_q <= mode_next;
            sel_q  <= (mode_next != '0) ? SEL_W'(1) : '0;
         end else if (sel_cmd) begin
            sel_q <= (sel_q == SEL_W'(NUM_FIELDS)) ? '0 : sel_q + SEL_W'(1);
         end else if (start_cmd) begin
            if (mode_q == MODE_W'(TIMER_MODE)) timer_en_q <= ~timer_en_q;
         end else if (alarm_cmd) begin
            alarm_en_q <= ~alarm_en_q;
         end
      end
   end

   assign ui.mode         = mode_q;
   assign ui.select       = sel_q;
   assign ui.increment    = increment_q;
   assign ui.timer_enable = timer_en_q;
   assign ui.alarm_enable = alarm_en_q;
endmodule
